// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state/requester types and counter sizing for the memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic {REQ_I, REQ_D} req_id_t;

  function automatic int cnt_w(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner selection; ARB_ROUND_ROBIN_EN selects round robin
// over fixed data-first priority. winner: 1 = data port, 0 = fetch port.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_served,
  output logic winner
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = REQ_D;
    if (i_req && d_req) begin
      winner = (last_served == REQ_D) ? REQ_I : REQ_D;
    end else if (i_req) begin
      winner = REQ_I;
    end
  end
`else
  logic unused_last;
  assign unused_last = last_served;
  // Data wins whenever it asks; fetch only when it is the sole requester.
  assign winner = (d_req || !i_req) ? REQ_D : REQ_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port fixed-latency memory arbiter between fetch and load/store;
// ARB_ROUND_ROBIN_EN enables round-robin grants under contention.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_done,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  m_read,
  output logic                  m_write,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  localparam int CNT_W = cnt_w(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  req_id_t               owner_q;
  logic                  we_q;
  logic                  winner;
  logic                  start, finish;
  logic                  pick_we;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [DATA_WIDTH-1:0] pick_wdata;
  logic                  last_served;

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_served <= REQ_I;
    end else if (start) begin
      last_served <= winner;
    end
  end
`else
  assign last_served = REQ_I;
`endif

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_served(last_served),
    .winner     (winner)
  );

  assign pick_we    = (winner == REQ_D) && d_we;
  assign pick_addr  = (winner == REQ_D) ? d_addr : i_addr;
  assign pick_wdata = (winner == REQ_D) ? d_wdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          start   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // m_addr/m_wdata double as the latched transaction operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      owner_q <= REQ_I;
      we_q    <= 1'b0;
      m_read  <= 1'b0;
      m_write <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_gnt   <= 1'b0;
      d_gnt   <= 1'b0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_gnt  <= 1'b0;
      d_gnt  <= 1'b0;
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (start) begin
        owner_q <= req_id_t'(winner);
        we_q    <= pick_we;
        cnt_q   <= CNT_LOAD;
        m_read  <= !pick_we;
        m_write <= pick_we;
        m_addr  <= pick_addr;
        m_wdata <= pick_wdata;
        i_gnt   <= (winner == REQ_I);
        d_gnt   <= (winner == REQ_D);
      end else if (finish) begin
        m_read  <= 1'b0;
        m_write <= 1'b0;
        if (owner_q == REQ_D) begin
          d_done  <= 1'b1;
          d_rdata <= we_q ? '0 : m_rdata;
        end else begin
          i_done  <= 1'b1;
          i_rdata <= m_rdata;
        end
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter at L=1,2,4 against a transaction timeline model
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [3:0] EXP_CODE = 4'b1010;
`else
  localparam logic [3:0] EXP_CODE = 4'b1110;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lanes_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int k);
    return (k == 16) ? 32'h8C010004 : (32'hA5A50000 ^ (k * 32'h01010101));
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    logic        reset = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_gnt, i_done, d_gnt, d_done, m_read, m_write;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    bit          loaded = 1'b0;

    int          edge_n = 0, next_sample = 0, s = 0;
    bit          act = 1'b0, own_d = 1'b0, own_we = 1'b0, last_d = 1'b0, w_d;
    logic [31:0] e_addr, e_wdata, e_rdata;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(L)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
      .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    assign m_rdata = mem[m_addr[9:2]];

    always @(posedge clk) begin
      if (!loaded) begin
        for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
        loaded <= 1'b1;
      end else if (m_write) begin
        mem[m_addr[9:2]] <= m_wdata;
      end
    end

    // Transaction model: one access per L+2 cycles, gnt at s+1, strobes s+1..s+L, done at s+L+1.
    always @(posedge clk) begin
      if (edge_n == 0) for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
      if (reset) begin
        act = 1'b0;
        last_d = 1'b0;
        next_sample = 0;
      end else if (edge_n >= next_sample && (i_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
        w_d = (i_req && d_req) ? !last_d : d_req;
        last_d = w_d;
`else
        w_d = d_req;
`endif
        act = 1'b1;
        s = edge_n;
        own_d = w_d;
        own_we = w_d && d_we;
        e_addr = w_d ? d_addr : i_addr;
        e_wdata = d_wdata;
        e_rdata = own_we ? 32'h0 : ref_mem[e_addr[9:2]];
        if (own_we) ref_mem[e_addr[9:2]] = d_wdata;
        next_sample = edge_n + L + 2;
      end
      edge_n++;
    end

    always @(negedge clk) begin
      logic [5:0] exp_v, got_v;
      int c;
      c = edge_n;
      if (reset) act = 1'b0;
      exp_v = '0;
      if (act) begin
        exp_v[5] = !own_d && c == s + 1;
        exp_v[4] = own_d && c == s + 1;
        exp_v[3] = !own_we && c >= s + 1 && c <= s + L;
        exp_v[2] = own_we && c >= s + 1 && c <= s + L;
        exp_v[1] = !own_d && c == s + L + 1;
        exp_v[0] = own_d && c == s + L + 1;
      end
      got_v = {i_gnt, d_gnt, m_read, m_write, i_done, d_done};
      chk($sformatf("L%0d cycle %0d gnt/strobe/done", L, c), got_v, exp_v);
      if (exp_v[3] || exp_v[2]) chk($sformatf("L%0d cycle %0d m_addr", L, c), m_addr, e_addr);
      if (exp_v[2]) chk($sformatf("L%0d cycle %0d m_wdata", L, c), m_wdata, e_wdata);
      if (exp_v[1]) chk($sformatf("L%0d cycle %0d i_rdata", L, c), i_rdata, e_rdata);
      if (exp_v[0]) chk($sformatf("L%0d cycle %0d d_rdata", L, c), d_rdata, e_rdata);
    end

    task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk($sformatf("L%0d reset outputs", L), {i_gnt, d_gnt, m_read, m_write, i_done, d_done}, 0);
      chk($sformatf("L%0d reset m_addr", L), m_addr, 0);
      chk($sformatf("L%0d reset data", L), m_wdata | i_rdata | d_rdata, 0);
      @(posedge clk); #1;
      reset = 1'b0;
    endtask

    task automatic lone_txn(input bit use_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_rd, input string nm);
      int strobes, done_at;
      logic [31:0] rd;
      strobes = 0; done_at = -1; rd = '0;
      @(posedge clk); #1;
      if (use_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; end
      else begin i_req = 1'b1; i_addr = addr; end
      @(posedge clk);
      for (int k = 1; k <= L + 2; k++) begin
        @(negedge clk);
        if (k == 1) begin
          chk($sformatf("L%0d %s gnt", L, nm), use_d ? d_gnt : i_gnt, 1);
          chk($sformatf("L%0d %s m_addr", L, nm), m_addr, addr);
          chk($sformatf("L%0d %s direction", L, nm), {m_read, m_write}, {!we, we});
        end
        if (m_read || m_write) strobes++;
        if (use_d ? d_done : i_done) begin
          done_at = k;
          rd = use_d ? d_rdata : i_rdata;
        end
        if (k == 1) begin
          @(posedge clk); #1;
          i_req = 1'b0; d_req = 1'b0;
        end
      end
      chk($sformatf("L%0d %s strobe width", L, nm), strobes, L);
      chk($sformatf("L%0d %s done cycle", L, nm), done_at, L + 1);
      chk($sformatf("L%0d %s rdata", L, nm), rd, exp_rd);
    endtask

    initial begin
      logic [3:0] code;
      int ng, ndone;
      bit gi, gd;

      do_reset();
      lone_txn(1'b0, 1'b0, 32'h40, 32'h0, 32'h8C010004, "fetch");
      lone_txn(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0, "store");
      lone_txn(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, "readback");

      do_reset();
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
      code = '0; ng = 0;
      for (int t = 0; t < 8 * (L + 2) && ng < 4; t++) begin
        @(negedge clk);
        if (i_gnt || d_gnt) begin
          code = {code[2:0], d_gnt};
          ng++;
          @(posedge clk); #1;
          if (ng == 3) d_req = 1'b0;
          if (ng == 4) i_req = 1'b0;
        end
      end
      chk($sformatf("L%0d contention grant count", L), ng, 4);
      chk($sformatf("L%0d contention grant order", L), code, EXP_CODE);
      i_req = 1'b0; d_req = 1'b0;
      repeat (L + 3) @(posedge clk);

      #1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      @(posedge clk); #2;
      chk($sformatf("L%0d load strobe before abort", L), m_read, 1);
      reset = 1'b1;
      #1;
      chk($sformatf("L%0d strobes on async reset", L), {m_read, m_write, d_gnt}, 0);
      @(posedge clk); #1;
      d_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      ndone = 0;
      repeat (L + 3) begin
        @(negedge clk);
        if (d_done || i_done) ndone++;
      end
      chk($sformatf("L%0d done after abort", L), ndone, 0);
      lone_txn(1'b0, 1'b0, 32'h40, 32'h0, 32'h8C010004, "post-reset fetch");

      for (int t = 0; t < 400; t++) begin
        @(negedge clk);
        gi = i_gnt; gd = d_gnt;
        @(posedge clk); #1;
        if (gi) i_req = 1'b0;
        if (gd) d_req = 1'b0;
        if (!i_req && $urandom_range(3) == 0) begin
          i_req = 1'b1;
          i_addr = 32'h100 + ($urandom_range(15) << 2);
        end
        if (!d_req && $urandom_range(2) == 0) begin
          d_req = 1'b1;
          d_we = 1'($urandom_range(1));
          d_addr = 32'h100 + ($urandom_range(15) << 2);
          d_wdata = $urandom;
        end
      end
      @(negedge clk);
      @(posedge clk); #1;
      i_req = 1'b0; d_req = 1'b0;
      repeat (2 * L + 6) @(posedge clk);
      lanes_done++;
    end
  end

  initial begin
    int t;
    t = 0;
    while (lanes_done < 3 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (lanes_done < 3) begin
      errors++;
      $display("FAIL timeout: lanes finished %0d, expected 3", lanes_done);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
